pll_lock_supervisor: RTL and testbench



---
 rtl/pll_sup_pkg.sv | 27 ++
 rtl/sync_2ff.sv | 24 ++
 rtl/pll_lock_supervisor.sv | 111 +++++++++++
 tb/tb_pll_lock_supervisor.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_sup_pkg.sv
// Shared types and helpers for the PLL lock supervisor: one-hot state
// encoding, default parameter values and the timer-width calculation.
package pll_sup_pkg;

  typedef enum logic [3:0] {
    WAIT_LOCK = 4'b0001,
    STABLE    = 4'b0010,
    RUN       = 4'b0100,
    PLL_RST   = 4'b1000
  } sup_state_e;

  localparam int DEF_STABLE_CYCLES  = 1024;
  localparam int DEF_TIMEOUT_CYCLES = 1048576;
  localparam int DEF_PLLRST_CYCLES  = 16;
  localparam int DEF_CNT_W          = 8;

  // Timer must reach (largest interval - 1); never narrower than one bit.
  function automatic int timer_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if ($clog2(m) < 1) return 1;
    else return $clog2(m);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for a single asynchronous level signal.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_supervisor.sv
// Holds downstream logic in reset until PLL lock has been stable, resets the
// PLL when lock never arrives, and counts relock and timeout events.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int PLLRST_CYCLES  = DEF_PLLRST_CYCLES,
  parameter int CNT_W          = DEF_CNT_W
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             lockedn,
  input  logic             clear_counts,
  output logic             pll_rst,
  output logic             rstn_out,
  output logic             ready,
  output logic [CNT_W-1:0] relock_count,
  output logic [CNT_W-1:0] timeout_count
);

  localparam int TW = timer_width(STABLE_CYCLES, TIMEOUT_CYCLES, PLLRST_CYCLES);
  localparam logic [TW-1:0]    STABLE_LAST  = TW'(STABLE_CYCLES - 1);
  localparam logic [TW-1:0]    TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0]    PLLRST_LAST  = TW'(PLLRST_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};

  sup_state_e    state;
  sup_state_e    state_nxt;
  logic [TW-1:0] timer;
  logic          sync_q;
  logic          locked_s;
  logic          relock_inc;
  logic          timeout_inc;

  // A simultaneous clear and event leaves a count of one so the event survives.
  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cur,
                                                input logic inc, input logic clr);
    if (inc && clr) return CNT_ONE;
    else if (clr) return {CNT_W{1'b0}};
    else if (inc && (cur != CNT_MAX)) return cur + CNT_ONE;
    else return cur;
  endfunction

  sync_2ff #(.RESET_VAL(1'b1)) u_lock_sync (
    .clk   (CLK),
    .rst_n (RST_N),
    .d     (lockedn),
    .q     (sync_q)
  );

  assign locked_s = ~sync_q;

  // Next-state and event decode.
  always_comb begin
    state_nxt   = state;
    relock_inc  = 1'b0;
    timeout_inc = 1'b0;
    case (state)
      WAIT_LOCK: begin
        if (locked_s) begin
          state_nxt = STABLE;
        end else if (timer == TIMEOUT_LAST) begin
          state_nxt   = PLL_RST;
          timeout_inc = 1'b1;
        end else begin
          state_nxt = WAIT_LOCK;
        end
      end
      STABLE: begin
        if (!locked_s) state_nxt = WAIT_LOCK;
        else if (timer == STABLE_LAST) state_nxt = RUN;
        else state_nxt = STABLE;
      end
      RUN: begin
        if (!locked_s) begin
          state_nxt  = WAIT_LOCK;
          relock_inc = 1'b1;
        end else begin
          state_nxt = RUN;
        end
      end
      PLL_RST: begin
        if (timer == PLLRST_LAST) state_nxt = WAIT_LOCK;
        else state_nxt = PLL_RST;
      end
      default: state_nxt = WAIT_LOCK;
    endcase
  end

  // State, shared interval timer and event counters.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state         <= WAIT_LOCK;
      timer         <= {TW{1'b0}};
      relock_count  <= {CNT_W{1'b0}};
      timeout_count <= {CNT_W{1'b0}};
    end else begin
      state         <= state_nxt;
      timer         <= (state_nxt != state) ? {TW{1'b0}} : timer + TW'(1);
      relock_count  <= cnt_next(relock_count, relock_inc, clear_counts);
      timeout_count <= cnt_next(timeout_count, timeout_inc, clear_counts);
    end
  end

  assign pll_rst  = (state == PLL_RST);
  assign ready    = (state == RUN);
  assign rstn_out = (state == RUN);

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Randomised and directed bench for pll_lock_supervisor, compared every cycle
// against a behavioural model of lock acquisition, timeouts and counters.
module tb_pll_lock_supervisor;

  localparam int S  = 8;
  localparam int T  = 32;
  localparam int P  = 4;
  localparam int CW = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic          CLK = 1'b0;
  logic          RST_N;
  logic          lockedn;
  logic          clear_counts;
  logic          pll_rst;
  logic          rstn_out;
  logic          ready;
  logic [CW-1:0] relock_count;
  logic [CW-1:0] timeout_count;

  int n_checks = 0;
  int n_fail   = 0;

  pll_lock_supervisor #(
    .STABLE_CYCLES  (S),
    .TIMEOUT_CYCLES (T),
    .PLLRST_CYCLES  (P),
    .CNT_W          (CW)
  ) dut (
    .CLK           (CLK),
    .RST_N         (RST_N),
    .lockedn       (lockedn),
    .clear_counts  (clear_counts),
    .pll_rst       (pll_rst),
    .rstn_out      (rstn_out),
    .ready         (ready),
    .relock_count  (relock_count),
    .timeout_count (timeout_count)
  );

  always #5 CLK = ~CLK;

  wire [2+2*CW:0] obs = {pll_rst, rstn_out, ready, relock_count, timeout_count};
  logic [2+2*CW:0] exp_vec;

  // Behavioural model: lock seen two edges late, stability streak,
  // unlocked wait time, remaining PLL reset pulse length, event counts.
  bit m_sync1, m_sync2, m_running, m_acq;
  int m_streak, m_wait, m_pulse, m_rel, m_to;

  function automatic int sat_next(int c, bit inc, bit clr);
    if (inc && clr) return 1;
    if (clr) return 0;
    if (inc) return (c < CMAX) ? c + 1 : CMAX;
    return c;
  endfunction

  task automatic model_reset();
    m_sync1 = 1'b1; m_sync2 = 1'b1;
    m_running = 1'b0; m_acq = 1'b0;
    m_streak = 0; m_wait = 0; m_pulse = 0; m_rel = 0; m_to = 0;
    exp_vec = '0;
  endtask

  task automatic model_step(bit l, bit clr);
    bit locked, ri, ti;
    locked = !m_sync2;
    ri = 1'b0; ti = 1'b0;
    m_sync2 = m_sync1;
    m_sync1 = l;
    if (m_pulse > 0) begin
      m_pulse--;
      if (m_pulse == 0) m_wait = 0;
    end else if (m_running) begin
      if (!locked) begin m_running = 1'b0; ri = 1'b1; m_wait = 0; end
    end else if (m_acq) begin
      if (!locked) begin
        m_acq = 1'b0; m_wait = 0;
      end else begin
        m_streak++;
        if (m_streak == S) begin m_acq = 1'b0; m_running = 1'b1; end
      end
    end else begin
      if (locked) begin
        m_acq = 1'b1; m_streak = 0;
      end else begin
        m_wait++;
        if (m_wait == T) begin m_pulse = P; ti = 1'b1; end
      end
    end
    m_rel = sat_next(m_rel, ri, clr);
    m_to  = sat_next(m_to, ti, clr);
    exp_vec = {(m_pulse > 0), m_running, m_running, CW'(m_rel), CW'(m_to)};
  endtask

  task automatic tick(bit l, bit clr);
    lockedn = l;
    clear_counts = clr;
    @(posedge CLK);
    model_step(l, clr);
    #1;
  endtask

  task automatic release_reset();
    @(negedge CLK);
    RST_N = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    RST_N = 1'b0; lockedn = 1'b1; clear_counts = 1'b0;
    model_reset();
    #3;
    n_checks++;
    if (obs !== '0) begin n_fail++; $display("FAIL reset_outputs: got %b expected %b", obs, '0); end
    repeat (2) @(posedge CLK);
    release_reset();
  endtask

  task automatic test_acquire();
    int n;
    repeat (3) begin
      tick(1'b1, 1'b0);
      n_checks++;
      if (obs !== exp_vec) begin n_fail++; $display("FAIL acquire_idle: got %b expected %b", obs, exp_vec); end
    end
    tick(1'b0, 1'b0);
    n = 0;
    while (!ready && n < 40) begin
      tick(1'b0, 1'b0);
      n++;
      n_checks++;
      if (obs !== exp_vec) begin n_fail++; $display("FAIL acquire_model: got %b expected %b", obs, exp_vec); end
    end
    n_checks++;
    if (n != 10) begin n_fail++; $display("FAIL acquire_latency: got %0d expected 10", n); end
  endtask

  task automatic test_relock();
    int n;
    tick(1'b1, 1'b0);
    n = 0;
    while (ready && n < 10) begin
      tick(1'b0, 1'b0);
      n++;
      n_checks++;
      if (obs !== exp_vec) begin n_fail++; $display("FAIL relock_model: got %b expected %b", obs, exp_vec); end
    end
    n_checks++;
    if (n != 2) begin n_fail++; $display("FAIL relock_drop_latency: got %0d expected 2", n); end
    n_checks++;
    if (relock_count !== CW'(1)) begin n_fail++; $display("FAIL relock_count: got %0d expected 1", relock_count); end
    while (!ready && n < 40) begin
      tick(1'b0, 1'b0);
      n++;
      n_checks++;
      if (obs !== exp_vec) begin n_fail++; $display("FAIL relock_model: got %b expected %b", obs, exp_vec); end
    end
    n_checks++;
    if (n != 11) begin n_fail++; $display("FAIL relock_return_latency: got %0d expected 11", n); end
  endtask

  task automatic test_glitch();
    int n;
    repeat (4) tick(1'b1, 1'b0);
    for (int i = 0; i < 7; i++) begin
      tick(1'b0, 1'b0);
      n_checks++;
      if (obs !== exp_vec) begin n_fail++; $display("FAIL glitch_model: got %b expected %b", obs, exp_vec); end
    end
    tick(1'b1, 1'b0);
    n = 0;
    while (!ready && n < 40) begin
      tick(1'b0, 1'b0);
      n++;
      n_checks++;
      if (obs !== exp_vec) begin n_fail++; $display("FAIL glitch_model: got %b expected %b", obs, exp_vec); end
    end
    n_checks++;
    if (n != 11) begin n_fail++; $display("FAIL glitch_restart: got %0d expected 11", n); end
  endtask

  task automatic test_timeout();
    int pulses, width, last_rise;
    bit prev;
    pulses = 0; width = 0; last_rise = -1; prev = 1'b0;
    for (int i = 0; i < 190; i++) begin
      tick(1'b1, 1'b0);
      n_checks++;
      if (obs !== exp_vec) begin n_fail++; $display("FAIL timeout_model: got %b expected %b", obs, exp_vec); end
      if (pll_rst && !prev) begin
        pulses++;
        if (last_rise >= 0) begin
          n_checks++;
          if (i - last_rise != T + P) begin
            n_fail++; $display("FAIL timeout_period: got %0d expected %0d", i - last_rise, T + P);
          end
        end
        last_rise = i;
      end
      if (pll_rst) width++;
      if (!pll_rst && prev) begin
        n_checks++;
        if (width != P) begin n_fail++; $display("FAIL pll_rst_width: got %0d expected %0d", width, P); end
        width = 0;
      end
      prev = pll_rst;
    end
    n_checks++;
    if (pulses != 5) begin n_fail++; $display("FAIL timeout_pulses: got %0d expected 5", pulses); end
    n_checks++;
    if (timeout_count !== CW'(CMAX)) begin
      n_fail++; $display("FAIL timeout_saturate: got %0d expected %0d", timeout_count, CMAX);
    end
  endtask

  task automatic test_clear();
    int n;
    n = 0;
    while (!ready && n < 80) begin
      tick(1'b0, 1'b0);
      n++;
    end
    n_checks++;
    if (!ready) begin n_fail++; $display("FAIL clear_reach_run: got %b expected 1", ready); end
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    n_checks++;
    if (relock_count !== CW'(1)) begin n_fail++; $display("FAIL clear_with_inc: got %0d expected 1", relock_count); end
    n_checks++;
    if (obs !== exp_vec) begin n_fail++; $display("FAIL clear_model: got %b expected %b", obs, exp_vec); end
    tick(1'b0, 1'b1);
    n_checks++;
    if (relock_count !== CW'(0)) begin n_fail++; $display("FAIL clear_alone: got %0d expected 0", relock_count); end
    tick(1'b0, 1'b0);
  endtask

  task automatic test_async_reset();
    int n;
    n = 0;
    while (!pll_rst && n < 60) begin
      tick(1'b1, 1'b0);
      n++;
    end
    n_checks++;
    if (!pll_rst) begin n_fail++; $display("FAIL areset_reach_pllrst: got %b expected 1", pll_rst); end
    #2 RST_N = 1'b0;
    #1;
    n_checks++;
    if (obs !== '0) begin n_fail++; $display("FAIL areset_in_pllrst: got %b expected %b", obs, '0); end
    release_reset();
    tick(1'b0, 1'b0);
    n = 0;
    while (!ready && n < 40) begin
      tick(1'b0, 1'b0);
      n++;
      n_checks++;
      if (obs !== exp_vec) begin n_fail++; $display("FAIL areset_model: got %b expected %b", obs, exp_vec); end
    end
    n_checks++;
    if (n != 10) begin n_fail++; $display("FAIL areset_reacquire: got %0d expected 10", n); end
    #2 RST_N = 1'b0;
    #1;
    n_checks++;
    if (obs !== '0) begin n_fail++; $display("FAIL areset_in_run: got %b expected %b", obs, '0); end
    release_reset();
  endtask

  task automatic test_random();
    bit l;
    int len;
    for (int i = 0; i < 1500; ) begin
      l = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 45);
      for (int j = 0; j < len; j++) begin
        tick(l, ($urandom_range(0, 15) == 0));
        i++;
        n_checks++;
        if (obs !== exp_vec) begin n_fail++; $display("FAIL random_model: got %b expected %b", obs, exp_vec); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_acquire();
    test_relock();
    test_glitch();
    test_timeout();
    test_clear();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
